// File: rtl/processing_block.sv
// 32-lane bf16 SIMD processing element: two-phase fetch/execute over a
// 16-entry 512-bit vector register file with lane-wise add and multiply.
module processing_block #(
  parameter int LANES    = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           instructions [65536],
  input  logic [LANES*16-1:0]   load_data,
  output logic [15:0]           load_addr,
  output logic [15:0]           write_addr,
  output logic [LANES*16-1:0]   write_data,
  output logic                  load_ctrl,
  output logic                  write_ctrl
);

  localparam int VW  = LANES * 16;
  localparam int RIW = $clog2(NUM_REGS);

  localparam logic [7:0] OP_LOAD  = 8'h20;
  localparam logic [7:0] OP_STORE = 8'h10;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h02;

  typedef enum logic {ISSUE, EXEC} phase_t;

  // Flush/overflow/round-to-nearest-even packing of a normalised result.
  function automatic logic [15:0] bf_pack(
    input logic               s,
    input logic signed [10:0] e,
    input logic [6:0]         m,
    input logic               g,
    input logic               st
  );
    logic [14:0] v;
    if (e <= 11'sd0) return {s, 15'd0};
    if (e >= 11'sd255) return {s, 8'hFF, 7'd0};
    v = {e[7:0], m} + 15'(g & (st | m[0]));
    return {s, v};
  endfunction

  function automatic logic [15:0] bf_mul(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic               s;
    logic [7:0]         ea, eb;
    logic [6:0]         ma, mb;
    logic [15:0]        p;
    logic signed [10:0] e;
    s  = a[15] ^ b[15];
    ea = a[14:7];
    eb = b[14:7];
    ma = a[6:0];
    mb = b[6:0];
    if ((ea == 8'hFF && ma != 7'd0) || (eb == 8'hFF && mb != 7'd0))
      return 16'h7FC0;
    if ((ea == 8'hFF && eb == 8'd0) || (eb == 8'hFF && ea == 8'd0))
      return 16'h7FC0;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 7'd0};
    if (ea == 8'd0 || eb == 8'd0) return {s, 15'd0};
    p = 16'({1'b1, ma}) * 16'({1'b1, mb});
    e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
      + $signed({10'd0, p[15]});
    if (p[15]) return bf_pack(s, e, p[14:8], p[7], |p[6:0]);
    return bf_pack(s, e, p[13:7], p[6], |p[5:0]);
  endfunction

  function automatic logic [15:0] bf_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic               sx, sy;
    logic [7:0]         ex, ey, d;
    logic [6:0]         mx, my;
    logic [31:0]        fx, fy, ys, sum, n;
    logic               stk;
    logic [4:0]         pos;
    logic signed [10:0] e;
    if ((a[14:7] == 8'hFF && a[6:0] != 7'd0) ||
        (b[14:7] == 8'hFF && b[6:0] != 7'd0))
      return 16'h7FC0;
    if (a[14:7] == 8'hFF && b[14:7] == 8'hFF)
      return (a[15] != b[15]) ? 16'h7FC0 : {a[15], 8'hFF, 7'd0};
    if (a[14:7] == 8'hFF) return {a[15], 8'hFF, 7'd0};
    if (b[14:7] == 8'hFF) return {b[15], 8'hFF, 7'd0};
    if (a[14:7] == 8'd0 && b[14:7] == 8'd0)
      return {a[15] & b[15], 15'd0};
    if (a[14:7] == 8'd0) return b;
    if (b[14:7] == 8'd0) return a;
    if (b[14:0] > a[14:0]) begin
      {sx, ex, mx} = b;
      {sy, ey, my} = a;
    end else begin
      {sx, ex, mx} = a;
      {sy, ey, my} = b;
    end
    d  = ex - ey;
    fx = {2'b01, mx, 23'd0};
    fy = {2'b01, my, 23'd0};
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (d >= 8'd32) begin
      ys  = 32'd0;
      stk = 1'b1;
    end else begin
      ys  = fy >> d;
      stk = |(fy & ~(32'hFFFF_FFFF << d));
    end
    ys[0] = ys[0] | stk;
    sum = (sx == sy) ? fx + ys : fx - ys;
    if (sum == 32'd0) return 16'h0000;
    pos = 5'd0;
    for (int i = 0; i < 32; i++)
      if (sum[i]) pos = 5'(i);
    n = sum << (5'd31 - pos);
    e = $signed({3'b000, ex}) + $signed({6'd0, pos}) - 11'sd30;
    return bf_pack(sx, e, n[30:24], n[23], |n[22:0]);
  endfunction

  phase_t         r_phase;
  phase_t         w_phase_nxt;
  logic [15:0]    r_pc;
  logic [VW-1:0]  r_regs [NUM_REGS];

  logic [31:0]    w_instr;
  logic [7:0]     w_op;
  logic [RIW-1:0] w_rd, w_ra, w_rb;
  logic [VW-1:0]  w_va, w_vb, w_vd;
  logic [VW-1:0]  w_add, w_mul;
  logic           w_wr_en;
  logic [VW-1:0]  w_wr_val;

  assign w_instr = instructions[r_pc];
  assign w_op    = w_instr[31:24];
  assign w_rd    = RIW'(w_instr[23:16] % NUM_REGS);
  assign w_ra    = RIW'(w_instr[15:8] % NUM_REGS);
  assign w_rb    = RIW'(w_instr[7:0] % NUM_REGS);
  assign w_va    = r_regs[w_ra];
  assign w_vb    = r_regs[w_rb];
  assign w_vd    = r_regs[w_rd];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_add[16*l +: 16] = bf_add(w_va[16*l +: 16], w_vb[16*l +: 16]);
    assign w_mul[16*l +: 16] = bf_mul(w_va[16*l +: 16], w_vb[16*l +: 16]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_phase <= ISSUE;
    else       r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = ISSUE;
    if (r_phase == ISSUE) w_phase_nxt = EXEC;
  end

  always_comb begin
    load_ctrl  = 1'b0;
    write_ctrl = 1'b0;
    load_addr  = 16'd0;
    write_addr = 16'd0;
    write_data = '0;
    w_wr_en    = 1'b0;
    w_wr_val   = '0;
    case (w_op)
      OP_LOAD: begin
        load_ctrl = 1'b1;
        load_addr = w_instr[15:0];
        w_wr_en   = 1'b1;
        w_wr_val  = load_data;
      end
      OP_STORE: begin
        write_ctrl = 1'b1;
        write_addr = w_instr[15:0];
        write_data = w_vd;
      end
      OP_ADD: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_add;
      end
      OP_MUL: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_mul;
      end
      default: ;
    endcase
  end

  // Commit and PC advance only on the edge that ends EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= 16'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_phase == EXEC) begin
      r_pc <= r_pc + 16'd1;
      if (w_wr_en) r_regs[w_rd] <= w_wr_val;
    end
  end

endmodule

// File: tb/tb_processing_block.sv
// Bench for processing_block: table of bf16 lane ops run as tiny programs
// with a store scoreboard, plus reset, timing and opcode sequences.
module tb_processing_block;

  localparam int VW = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   imem [65536];
  logic [VW-1:0] mem [16];
  logic [VW-1:0] load_data;
  logic [15:0]   load_addr, write_addr;
  logic [VW-1:0] write_data;
  logic          load_ctrl, write_ctrl;

  int n_vec = 0;
  int n_err = 0;
  logic [VW-1:0] sb_q [$];

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [15];

  processing_block dut (
    .clock        (clock),
    .reset        (reset),
    .instructions (imem),
    .load_data    (load_data),
    .load_addr    (load_addr),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .load_ctrl    (load_ctrl),
    .write_ctrl   (write_ctrl)
  );

  always #5 clock = ~clock;

  assign load_data = mem[load_addr[3:0]];

  function automatic logic [31:0] i_ld(input logic [7:0] rd,
                                       input logic [15:0] ad);
    return {8'h20, rd, ad};
  endfunction

  function automatic logic [31:0] i_st(input logic [7:0] rs,
                                       input logic [15:0] ad);
    return {8'h10, rs, ad};
  endfunction

  function automatic logic [31:0] i_alu(input logic [7:0] op,
                                        input logic [7:0] rd,
                                        input logic [7:0] ra,
                                        input logic [7:0] rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [VW-1:0] rep(input logic [15:0] v);
    return {32{v}};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) imem[i] = 32'h0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Bounded wait for a store; pops the scoreboard and compares write_data.
  task automatic wait_store(input string nm, output int cyc);
    logic seen;
    logic [VW-1:0] e;
    seen = 1'b0;
    cyc  = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (write_ctrl) begin
        seen = 1'b1;
        cyc  = k;
        break;
      end
    end
    if (!seen || sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no store seen (queue %0d)", nm, sb_q.size());
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk(nm, write_data, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [VW-1:0] alt_a, alt_e;

    tbl[0]  = '{8'h01, 16'h3F80, 16'h3B80, 16'h3F80};
    tbl[1]  = '{8'h01, 16'h3F81, 16'h3B80, 16'h3F82};
    tbl[2]  = '{8'h02, 16'h7F80, 16'h0000, 16'h7FC0};
    tbl[3]  = '{8'h02, 16'h7F00, 16'h4000, 16'h7F80};
    tbl[4]  = '{8'h01, 16'h0001, 16'h0000, 16'h0000};
    tbl[5]  = '{8'h01, 16'h3F80, 16'h3F80, 16'h4000};
    tbl[6]  = '{8'h02, 16'h3FC0, 16'h3FC0, 16'h4010};
    tbl[7]  = '{8'h01, 16'h3F80, 16'hBF80, 16'h0000};
    tbl[8]  = '{8'h01, 16'h8000, 16'h8000, 16'h8000};
    tbl[9]  = '{8'h01, 16'h7F80, 16'hFF80, 16'h7FC0};
    tbl[10] = '{8'h02, 16'h7FC1, 16'h3F80, 16'h7FC0};
    tbl[11] = '{8'h02, 16'hC000, 16'h4040, 16'hC0C0};
    tbl[12] = '{8'h02, 16'h0080, 16'h3F00, 16'h0000};
    tbl[13] = '{8'h01, 16'h4000, 16'hBF80, 16'h3F80};
    tbl[14] = '{8'hFF, 16'h3F80, 16'h3F80, 16'h0000};

    for (int i = 0; i < 65536; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset held from time 0: outputs follow instructions[0] at once.
    imem[0] = i_ld(8'd0, 16'd0);
    imem[1] = i_ld(8'd1, 16'd1);
    #1;
    chk("rst_load_ctrl", VW'(load_ctrl), VW'(1));
    chk("rst_load_addr", VW'(load_addr), VW'(0));
    chk("rst_write_ctrl", VW'(write_ctrl), VW'(0));
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("exec_load_addr", VW'(load_addr), VW'(0));
    @(negedge clock);
    chk("pc1_load_addr", VW'(load_addr), VW'(1));
    chk("pc1_load_ctrl", VW'(load_ctrl), VW'(1));

    // Reference program from the datasheet example.
    clear_prog();
    mem[0] = rep(16'h3E4D);
    mem[1] = rep(16'h4000);
    mem[2] = rep(16'h3E4D);
    imem[0] = i_ld(8'd0, 16'd0);
    imem[1] = i_ld(8'd1, 16'd1);
    imem[2] = i_ld(8'd2, 16'd2);
    imem[3] = i_alu(8'h02, 8'd3, 8'd0, 8'd1);
    imem[4] = i_alu(8'h01, 8'd4, 8'd3, 8'd2);
    imem[5] = i_st(8'd4, 16'd3);
    sb_q.push_back(rep(16'h3F1A));
    pulse_reset();
    wait_store("prog_data", cyc);
    chk("prog_addr", VW'(write_addr), VW'(3));
    chk("prog_cycle", VW'(cyc), VW'(9));

    // Table: LOAD a, LOAD b, op, STORE; register fields exercise mod 16.
    for (int i = 0; i < 15; i++) begin
      clear_prog();
      mem[0] = rep(tbl[i].a);
      mem[1] = rep(tbl[i].b);
      imem[0] = i_ld(8'd0, 16'd0);
      imem[1] = i_ld(8'd1, 16'd1);
      imem[2] = i_alu(tbl[i].op, 8'h12, 8'h10, 8'h21);
      imem[3] = i_st(8'h02, 16'd2);
      sb_q.push_back(rep(tbl[i].exp));
      pulse_reset();
      wait_store($sformatf("vec%0d", i), cyc);
      chk($sformatf("vec%0d_cycle", i), VW'(cyc), VW'(5));
    end

    // Lanes independent: alternating 1.0/2.0 plus 1.0 -> 2.0/3.0.
    for (int l = 0; l < 32; l++) begin
      alt_a[16*l +: 16] = l[0] ? 16'h4000 : 16'h3F80;
      alt_e[16*l +: 16] = l[0] ? 16'h4040 : 16'h4000;
    end
    clear_prog();
    mem[0] = alt_a;
    mem[1] = rep(16'h3F80);
    imem[0] = i_ld(8'd7, 16'd0);
    imem[1] = i_ld(8'd8, 16'd1);
    imem[2] = i_alu(8'h01, 8'd9, 8'd7, 8'd8);
    imem[3] = i_st(8'd9, 16'd5);
    sb_q.push_back(alt_e);
    pulse_reset();
    wait_store("lanes", cyc);
    chk("lanes_addr", VW'(write_addr), VW'(5));

    // Reset in EXEC of a LOAD: PC back to 0, register untouched.
    clear_prog();
    mem[0] = rep(16'h3F80);
    imem[0] = 32'hFF00_0000;
    imem[1] = i_ld(8'd5, 16'd0);
    pulse_reset();
    @(negedge clock);
    @(negedge clock);
    chk("pre_abort_ld", VW'(load_ctrl), VW'(1));
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_pc0", VW'(load_ctrl), VW'(0));
    imem[0] = i_st(8'd5, 16'd4);
    #1;
    chk("abort_wctrl", VW'(write_ctrl), VW'(1));
    chk("abort_reg", write_data, '0);
    #1;
    reset = 1'b0;

    // Unknown opcode 0xFF: nothing asserted, PC advances after 2 edges.
    clear_prog();
    imem[0] = 32'hFF12_3456;
    imem[1] = i_ld(8'd0, 16'd7);
    pulse_reset();
    #1;
    chk("nop_issue", VW'({load_ctrl, write_ctrl}), VW'(0));
    @(negedge clock);
    chk("nop_exec", VW'({load_ctrl, write_ctrl}), VW'(0));
    chk("nop_addr", VW'(load_addr), VW'(0));
    @(negedge clock);
    chk("nop_next_ctrl", VW'(load_ctrl), VW'(1));
    chk("nop_next_addr", VW'(load_addr), VW'(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
